// File: rtl/floating_point_multiplier.sv
// floating_point_multiplier: 4-stage streaming IEEE-style multiplier, RNE rounding, denormals flushed to zero
module floating_point_multiplier #(
  parameter int EXP_WIDTH = 8,
  parameter int FRAC_WIDTH = 23,
  localparam int FP_WIDTH_REG = 1 + EXP_WIDTH + FRAC_WIDTH
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic [FP_WIDTH_REG-1:0] fp_a_i,
  input  logic [FP_WIDTH_REG-1:0] fp_b_i,
  input  logic                    valid_i,
  output logic [FP_WIDTH_REG-1:0] fp_o,
  output logic                    valid_o
);
  localparam int EW = EXP_WIDTH;
  localparam int FW = FRAC_WIDTH;
  localparam int MW = FW + 1;
  localparam int PW = 2 * MW;
  localparam int BIAS = (1 << (EW - 1)) - 1;
  localparam logic signed [EW+1:0] EMAX = (EW+2)'((1 << EW) - 1);
  localparam logic [FP_WIDTH_REG-1:0] QNAN = {1'b0, {EW{1'b1}}, 1'b1, {(FW-1){1'b0}}};
  logic [FP_WIDTH_REG-1:0] r1_a, r1_b, r4_y;
  logic r1_v, r2_v, r3_v, r4_v;
  logic r2_sg, r2_nan, r2_inf, r2_zero, r3_sg, r3_nan, r3_inf, r3_zero;
  logic signed [EW+1:0] r2_e, r3_e;
  logic [PW-1:0] r2_p;
  logic [FW-1:0] r3_m;
  logic r3_g, r3_s;
  logic [EW-1:0] w_ea, w_eb;
  logic [FW-1:0] w_fa, w_fb;
  logic w_za, w_zb, w_ia, w_ib, w_na, w_nb, w_hi;
  logic signed [EW+1:0] w_e2, w_e4;
  logic [PW-1:0] w_ma, w_mb;
  logic [MW-1:0] w_rnd;
  logic [FP_WIDTH_REG-1:0] w_inf, w_zero, w_y;
  always_comb begin
    w_ea = r1_a[FW +: EW];
    w_eb = r1_b[FW +: EW];
    w_fa = r1_a[FW-1:0];
    w_fb = r1_b[FW-1:0];
    w_za = w_ea == '0;
    w_zb = w_eb == '0;
    w_ia = &w_ea && w_fa == '0;
    w_ib = &w_eb && w_fb == '0;
    w_na = &w_ea && |w_fa;
    w_nb = &w_eb && |w_fb;
    w_e2 = {2'b0, w_ea} + {2'b0, w_eb} - (EW+2)'(BIAS);
    w_ma = {{MW{1'b0}}, 1'b1, w_fa};
    w_mb = {{MW{1'b0}}, 1'b1, w_fb};
    w_hi = r2_p[PW-1];
    w_rnd = {1'b0, r3_m} + MW'(r3_g & (r3_s | r3_m[0]));
    w_e4 = r3_e + (EW+2)'(w_rnd[FW]);
    w_inf = {r3_sg, {EW{1'b1}}, {FW{1'b0}}};
    w_zero = {r3_sg, {(EW+FW){1'b0}}};
    w_y = r3_nan ? QNAN : r3_inf ? w_inf : r3_zero ? w_zero :
          w_e4 >= EMAX ? w_inf : (w_e4[EW+1] || w_e4 == '0) ? w_zero :
          {r3_sg, w_e4[EW-1:0], w_rnd[FW-1:0]};
  end
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r1_a <= '0;
      r1_b <= '0;
      r1_v <= 1'b0;
      r2_sg <= 1'b0;
      r2_nan <= 1'b0;
      r2_inf <= 1'b0;
      r2_zero <= 1'b0;
      r2_e <= '0;
      r2_p <= '0;
      r2_v <= 1'b0;
      r3_sg <= 1'b0;
      r3_nan <= 1'b0;
      r3_inf <= 1'b0;
      r3_zero <= 1'b0;
      r3_e <= '0;
      r3_m <= '0;
      r3_g <= 1'b0;
      r3_s <= 1'b0;
      r3_v <= 1'b0;
      r4_y <= '0;
      r4_v <= 1'b0;
    end else begin
      r1_a <= fp_a_i;
      r1_b <= fp_b_i;
      r1_v <= valid_i;
      r2_sg <= r1_a[FP_WIDTH_REG-1] ^ r1_b[FP_WIDTH_REG-1];
      r2_nan <= w_na | w_nb | (w_za & w_ib) | (w_ia & w_zb);
      r2_inf <= w_ia | w_ib;
      r2_zero <= w_za | w_zb;
      r2_e <= w_e2;
      r2_p <= w_ma * w_mb;
      r2_v <= r1_v;
      r3_sg <= r2_sg;
      r3_nan <= r2_nan;
      r3_inf <= r2_inf;
      r3_zero <= r2_zero;
      // product of two [1,2) mantissas lies in [1,4); top bit picks the binade
      r3_e <= r2_e + (EW+2)'(w_hi);
      r3_m <= w_hi ? r2_p[PW-2 -: FW] : r2_p[PW-3 -: FW];
      r3_g <= w_hi ? r2_p[PW-2-FW] : r2_p[PW-3-FW];
      r3_s <= w_hi ? |r2_p[PW-3-FW:0] : |r2_p[PW-4-FW:0];
      r3_v <= r2_v;
      r4_y <= w_y;
      r4_v <= r3_v;
    end
  end
  assign fp_o = r4_y;
  assign valid_o = r4_v;
endmodule
